// File: rtl/sdram_port_arbiter.sv
// Arbitrates a single SDRAM request port between a ROM loader (one-entry buffer)
// and a CPU strobe interface, with a per-access wait timeout.
//
// state    | meaning
// IDLE     | no access in flight; picks loader buffer first, then CPU
// DL_WR    | writing the buffered loader byte, mem_we high
// CPU_RD   | CPU read in flight, mem_rd high
// CPU_WR   | CPU write in flight, mem_we high
// CPU_HOLD | access done; waits for the CPU to release its strobes
module sdram_port_arbiter #(
    parameter int AW      = 23,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          cpu_ce_n,
    input  logic          cpu_oe_n,
    input  logic          cpu_we_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_rdy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready,
    output logic          dl_overrun,
    output logic          timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        DL_WR,
        CPU_RD,
        CPU_WR,
        CPU_HOLD
    } state_t;

    // Request is held for TIMEOUT cycles; the last one carries this count.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    wait_cnt;
    logic          dl_pend;
    logic [AW-1:0] dl_buf_addr;
    logic [DW-1:0] dl_buf_data;
    logic          in_access;
    logic          timeout_hit;
    logic          access_done;
    logic          dl_drain;
    logic          cpu_done;

    always_comb begin
        in_access   = (state == DL_WR) || (state == CPU_RD) || (state == CPU_WR);
        timeout_hit = in_access && !mem_ready && (wait_cnt == TIMEOUT_LAST);
        access_done = in_access && (mem_ready || timeout_hit);
        dl_drain    = (state == DL_WR) && access_done;
        cpu_done    = ((state == CPU_RD) || (state == CPU_WR)) && access_done;
        mem_we      = (state == DL_WR) || (state == CPU_WR);
        mem_rd      = (state == CPU_RD);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A loader strobe arriving this cycle still beats the CPU.
                if (dl_pend) begin
                    state_next = DL_WR;
                end else if (!dl_wr && !dl_active && !cpu_ce_n) begin
                    if (!cpu_we_n) begin
                        state_next = CPU_WR;
                    end else if (!cpu_oe_n) begin
                        state_next = CPU_RD;
                    end
                end
            end
            DL_WR: begin
                if (access_done) state_next = IDLE;
            end
            CPU_RD, CPU_WR: begin
                if (access_done) state_next = CPU_HOLD;
            end
            CPU_HOLD: begin
                if (cpu_ce_n || (cpu_oe_n && cpu_we_n)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wait_cnt    <= 8'd0;
            dl_pend     <= 1'b0;
            dl_buf_addr <= '0;
            dl_buf_data <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_dout    <= '0;
            cpu_rdy     <= 1'b0;
            dl_overrun  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (in_access && (state_next == state)) ? wait_cnt + 8'd1 : 8'd0;

            if (dl_wr && (!dl_pend || dl_drain)) begin
                dl_pend     <= 1'b1;
                dl_buf_addr <= dl_addr;
                dl_buf_data <= dl_data;
            end else if (dl_drain) begin
                dl_pend <= 1'b0;
            end

            if (dl_wr && dl_pend && !dl_drain) dl_overrun <= 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;

            if ((state == IDLE) && (state_next != IDLE)) begin
                if (state_next == DL_WR) begin
                    mem_addr <= dl_buf_addr;
                    mem_din  <= dl_buf_data;
                end else begin
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_din;
                end
            end

            if ((state == CPU_RD) && mem_ready) cpu_dout <= mem_dout;
            cpu_rdy <= cpu_done;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: loader writes, overrun, CPU read/write,
// contention, timeout and reset abort, all against hand-computed values.
module tb_sdram_port_arbiter;

    localparam int AW = 23;
    localparam int DW = 8;

    logic          clk_sys;
    logic          reset;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [DW-1:0] dl_data;
    logic          cpu_ce_n;
    logic          cpu_oe_n;
    logic          cpu_we_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_rdy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;
    logic          dl_overrun;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(255)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .cpu_ce_n    (cpu_ce_n),
        .cpu_oe_n    (cpu_oe_n),
        .cpu_we_n    (cpu_we_n),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_rdy     (cpu_rdy),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_dout    (mem_dout),
        .mem_ready   (mem_ready),
        .dl_overrun  (dl_overrun),
        .timeout_err (timeout_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, exp finish before 200000ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_release();
        cpu_ce_n = 1'b1;
        cpu_oe_n = 1'b1;
        cpu_we_n = 1'b1;
    endtask

    initial begin
        int nhigh;
        int nrise;
        int bad_addr;
        int nrd;
        int nrdy;
        logic prev_we;

        reset     = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        cpu_release();
        cpu_addr  = '0;
        cpu_din   = '0;
        mem_dout  = '0;
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        cyc();
        cyc();
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_cpu_rdy", 32'(cpu_rdy), 32'h0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_flags", {30'd0, dl_overrun, timeout_err}, 32'h0);
        reset = 1'b0;
        cyc();

        // Loader write, mem_ready in the third request cycle
        dl_active = 1'b1;
        dl_wr = 1'b1; dl_addr = 23'h000100; dl_data = 8'hA5;
        cyc();
        dl_wr = 1'b0;
        chk("dl_buffered_we", 32'(mem_we), 32'h0);
        cyc();
        chk("dl_we_c1", 32'(mem_we), 32'h1);
        chk("dl_addr", 32'(mem_addr), 32'h000100);
        chk("dl_din", 32'(mem_din), 32'hA5);
        chk("dl_rd_low", 32'(mem_rd), 32'h0);
        cyc();
        chk("dl_we_c2", 32'(mem_we), 32'h1);
        cyc();
        chk("dl_we_c3", 32'(mem_we), 32'h1);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("dl_we_done", 32'(mem_we), 32'h0);
        chk("dl_no_overrun", 32'(dl_overrun), 32'h0);

        // Overrun: second strobe lands while the first is still in flight
        dl_wr = 1'b1; dl_addr = 23'h000200; dl_data = 8'h11;
        cyc();
        nhigh = 0; nrise = 0; bad_addr = 0; prev_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (mem_we && !prev_we) nrise++;
            if (mem_we) nhigh++;
            if (mem_we && mem_addr != 23'h000200) bad_addr++;
            prev_we = mem_we;
            mem_ready = mem_we && (nhigh == 5);
            dl_wr = (i == 1);
            dl_addr = 23'h000300; dl_data = 8'h22;
            cyc();
        end
        dl_wr = 1'b0;
        mem_ready = 1'b0;
        chk("ovr_bursts", 32'(nrise), 32'd1);
        chk("ovr_we_cycles", 32'(nhigh), 32'd5);
        chk("ovr_addr_bad", 32'(bad_addr), 32'd0);
        chk("ovr_flag", 32'(dl_overrun), 32'h1);

        // CPU read with strobe held low afterwards
        dl_active = 1'b0;
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_addr = 23'h004000;
        cyc();
        chk("rd_mem_rd", 32'(mem_rd), 32'h1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h004000);
        chk("rd_we_low", 32'(mem_we), 32'h0);
        mem_dout = 8'h3C; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; mem_dout = 8'hFF;
        chk("rd_rdy", 32'(cpu_rdy), 32'h1);
        chk("rd_dout", 32'(cpu_dout), 32'h3C);
        nrd = 0; nrdy = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (mem_rd) nrd++;
            if (cpu_rdy) nrdy++;
        end
        chk("rd_hold_no_rd", 32'(nrd), 32'd0);
        chk("rd_hold_no_rdy", 32'(nrdy), 32'd0);
        cpu_release();
        cyc();
        chk("rd_dout_hold", 32'(cpu_dout), 32'h3C);

        // Contention: loader strobe and CPU write (both strobes low) together
        dl_wr = 1'b1; dl_addr = 23'h000555; dl_data = 8'h5A;
        cpu_ce_n = 1'b0; cpu_we_n = 1'b0; cpu_oe_n = 1'b0;
        cpu_addr = 23'h000777; cpu_din = 8'hC3;
        cyc();
        dl_wr = 1'b0;
        chk("ct_idle_we", 32'(mem_we), 32'h0);
        cyc();
        chk("ct_dl_we", 32'(mem_we), 32'h1);
        chk("ct_dl_addr", 32'(mem_addr), 32'h000555);
        chk("ct_dl_din", 32'(mem_din), 32'h5A);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("ct_gap_we", 32'(mem_we), 32'h0);
        chk("ct_gap_rdy", 32'(cpu_rdy), 32'h0);
        cyc();
        chk("ct_cpu_we", 32'(mem_we), 32'h1);
        chk("ct_cpu_rd_low", 32'(mem_rd), 32'h0);
        chk("ct_cpu_addr", 32'(mem_addr), 32'h000777);
        chk("ct_cpu_din", 32'(mem_din), 32'hC3);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("ct_rdy", 32'(cpu_rdy), 32'h1);
        chk("ct_we_done", 32'(mem_we), 32'h0);
        chk("ct_dout_kept", 32'(cpu_dout), 32'h3C);
        cpu_release();
        cyc();
        chk("ct_rdy_pulse", 32'(cpu_rdy), 32'h0);

        // Stray mem_ready while idle
        mem_dout = 8'hEE; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("stray_rdy", 32'(cpu_rdy), 32'h0);
        chk("stray_req", {30'd0, mem_we, mem_rd}, 32'h0);
        chk("stray_dout", 32'(cpu_dout), 32'h3C);

        // CPU stalls during download, then times out
        dl_active = 1'b1;
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_addr = 23'h000ABC;
        nrd = 0; nrdy = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (mem_rd) nrd++;
            if (cpu_rdy) nrdy++;
        end
        chk("stall_rd", 32'(nrd), 32'd0);
        chk("stall_rdy", 32'(nrdy), 32'd0);
        dl_active = 1'b0; mem_dout = 8'h99;
        cyc();
        chk("to_start_rd", 32'(mem_rd), 32'h1);
        chk("to_err_before", 32'(timeout_err), 32'h0);
        nrd = 0;
        while (mem_rd && nrd < 400) begin
            nrd++;
            cyc();
        end
        chk("to_rd_cycles", 32'(nrd), 32'd255);
        chk("to_rd_low", 32'(mem_rd), 32'h0);
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_rdy", 32'(cpu_rdy), 32'h1);
        chk("to_dout", 32'(cpu_dout), 32'h3C);
        cpu_release();
        cyc();
        chk("to_err_sticky", 32'(timeout_err), 32'h1);
        chk("ovr_sticky", 32'(dl_overrun), 32'h1);

        // Reset in the middle of a read
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_addr = 23'h000042;
        cyc();
        chk("rr_rd_before", 32'(mem_rd), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rr_rd_async", 32'(mem_rd), 32'h0);
        chk("rr_addr_async", 32'(mem_addr), 32'h0);
        chk("rr_dout_async", 32'(cpu_dout), 32'h0);
        chk("rr_flags_async", {30'd0, dl_overrun, timeout_err}, 32'h0);
        cyc();
        chk("rr_no_rdy", 32'(cpu_rdy), 32'h0);
        reset = 1'b0; mem_dout = 8'h77;
        cyc();
        chk("rr_new_rd", 32'(mem_rd), 32'h1);
        chk("rr_new_addr", 32'(mem_addr), 32'h000042);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("rr_new_rdy", 32'(cpu_rdy), 32'h1);
        chk("rr_new_dout", 32'(cpu_dout), 32'h77);
        cpu_release();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 23, memory address width
- DW, 8, data width
- TIMEOUT, 255, max cycles to wait for mem_ready
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_sys, in, 1, system clock
- reset, in, 1, asynchronous, active-high
- dl_active, in, 1, loader download in progress
- dl_wr, in, 1, one-cycle loader write strobe
- dl_addr, in, AW, loader address
- dl_data, in, DW, loader data
- cpu_ce_n, in, 1, CPU chip select, low active
- cpu_oe_n, in, 1, CPU read strobe, low active
- cpu_we_n, in, 1, CPU write strobe, low active
- cpu_addr, in, AW, CPU address
- cpu_din, in, DW, CPU write data
- cpu_dout, out, DW, CPU read data
- cpu_rdy, out, 1, one-cycle CPU completion pulse
- mem_addr, out, AW, SDRAM address
- mem_din, out, DW, SDRAM write data
- mem_we, out, 1, SDRAM write request (level)
- mem_rd, out, 1, SDRAM read request (level)
- mem_dout, in, DW, SDRAM read data
- mem_ready, in, 1, one-cycle SDRAM completion pulse
- dl_overrun, out, 1, sticky: loader write dropped
- timeout_err, out, 1, sticky: SDRAM access timed out

Function
REQ-003 FSM states SHALL be IDLE, DL_WR, CPU_RD, CPU_WR, CPU_HOLD.
REQ-004 A one-entry loader buffer SHALL capture dl_addr/dl_data on dl_wr and set dl_pend.
REQ-005 dl_wr while dl_pend=1 and not draining that cycle SHALL drop the new write and set dl_overrun.
REQ-006 dl_wr in the same cycle that dl_pend clears SHALL be accepted, with no overrun.
REQ-007 In IDLE, dl_pend=1 SHALL take priority and go to DL_WR.
REQ-008 In IDLE with dl_pend=0, dl_active=0 and cpu_ce_n=0: cpu_we_n=0 SHALL go to CPU_WR; otherwise cpu_oe_n=0 SHALL go to CPU_RD.
REQ-009 If cpu_we_n and cpu_oe_n are both low, write SHALL win.
REQ-010 While dl_active=1, CPU requests SHALL stall with cpu_rdy=0.
REQ-011 Address, data and operation SHALL be registered on the IDLE exit edge.
REQ-012 mem_we or mem_rd SHALL assert in the first cycle of DL_WR/CPU_WR/CPU_RD and hold until mem_ready.
REQ-013 Exactly one of mem_we/mem_rd SHALL be high at a time.
REQ-014 mem_addr and mem_din SHALL stay stable while a request is asserted.
REQ-015 On mem_ready in DL_WR: clear dl_pend, drop mem_we, return to IDLE.
REQ-016 On mem_ready in CPU_RD: latch mem_dout into cpu_dout, pulse cpu_rdy the next cycle, go to CPU_HOLD.
REQ-017 On mem_ready in CPU_WR: pulse cpu_rdy the next cycle, go to CPU_HOLD.
REQ-018 CPU_HOLD SHALL return to IDLE only when cpu_oe_n=1 and cpu_we_n=1 (or cpu_ce_n=1), so one strobe makes one access.
REQ-019 cpu_dout SHALL hold its value until the next completed CPU read.
REQ-020 An 8-bit wait counter SHALL clear on state entry and increment each cycle in DL_WR/CPU_RD/CPU_WR.
REQ-021 When the wait counter reaches TIMEOUT without mem_ready:
- drop the request and set timeout_err
- DL_WR: clear dl_pend, go to IDLE
- CPU_*: pulse cpu_rdy with cpu_dout unchanged, go to CPU_HOLD
REQ-022 mem_ready outside DL_WR/CPU_RD/CPU_WR SHALL be ignored.
REQ-023 Fixed latency: request visible at IDLE cycle n gives mem_* high at n+1; mem_ready at cycle m gives cpu_rdy at m+1.

Reset
REQ-024 While reset=1, asynchronously: FSM=IDLE, dl_pend=0, wait counter=0, all outputs 0 (cpu_dout, mem_addr, mem_din included).
REQ-025 Reset during an access SHALL abort it with no cpu_rdy pulse, and the buffered loader write SHALL be lost.
REQ-026 dl_overrun and timeout_err SHALL clear only on reset.

Verification
REQ-027 Loader write: dl_active=1, dl_wr with addr 0x000100, data 0xA5; mem_ready 3 cycles later -> mem_we=1 with those values for 3 cycles, then 0, dl_overrun=0.
REQ-028 Overrun: two dl_wr 1 cycle apart, mem_ready delayed 5 cycles -> second write dropped, dl_overrun=1, exactly one mem_we burst.
REQ-029 CPU read: dl_active=0, ce_n=0, oe_n=0, addr 0x4000; mem_dout=0x3C with mem_ready -> cpu_rdy one cycle later, cpu_dout=0x3C; no second mem_rd while oe_n stays low.
REQ-030 Contention: dl_wr and a CPU write request in the same cycle -> loader write serviced first, then CPU write, then cpu_rdy.
REQ-031 Timeout: CPU read, mem_ready never asserted -> after 255 cycles mem_rd=0, timeout_err=1, cpu_rdy pulse, cpu_dout unchanged.
REQ-032 Reset mid-read: reset asserted while mem_rd=1 -> all outputs 0 immediately, no cpu_rdy; after release, FSM idle and a new read works.
